// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N decoder with one-hot, thermometer, auto-scan and one-shot modes.
// Loads use a valid/ready handshake; a change of mode clears all datapath state.
module decoder_nx_seq #(
  parameter int N         = 3,
  parameter int SCAN_DIV  = 4,
  parameter int PULSE_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      scan_idx,
  output logic              busy
);

  localparam int W     = 2 ** N;
  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  localparam logic [W-1:0]     ONE        = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     ALL        = {W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_PULSE  = 2'b11
  } mode_t;

  mode_t            mode_q, mode_in;
  logic [W-1:0]     out_q, out_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             load;

  assign mode_in  = mode_t'(mode);
  assign in_ready = (mode_q == MODE_PULSE) ? !busy_q : 1'b1;
  assign load     = in_valid && in_ready;

  // The stored mode acts as the state; a differing input mode is a flush edge.
  always_comb begin
    out_d  = out_q;
    idx_d  = idx_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (mode_in != mode_q) begin
      out_d  = '0;
      idx_d  = '0;
      div_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (!en) begin
      out_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
      if (load) idx_d = sel;
    end else begin
      case (mode_q)
        MODE_ONEHOT: begin
          if (load) begin
            idx_d = sel;
            out_d = ONE << sel;
          end
        end
        MODE_THERM: begin
          if (load) begin
            idx_d = sel;
            out_d = ~((ALL << sel) << 1);
          end
        end
        MODE_SCAN: begin
          // A load restarts the dwell and wins over a pending increment.
          if (load) begin
            idx_d = sel;
            div_d = '0;
          end else if (div_q == DIV_LAST) begin
            idx_d = idx_q + N'(1);
            div_d = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          out_d = ONE << idx_d;
        end
        MODE_PULSE: begin
          if (busy_q) begin
            if (cnt_q == '0) begin
              out_d  = '0;
              busy_d = 1'b0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else if (load) begin
            idx_d  = sel;
            out_d  = ONE << sel;
            busy_d = 1'b1;
            cnt_d  = PULSE_LAST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_ONEHOT;
      out_q  <= '0;
      idx_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode_in;
      out_q  <= out_d;
      idx_q  <= idx_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign out      = out_q;
  assign scan_idx = idx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Self-checking bench for decoder_nx_seq: three widths (N=3, N=1, N=4) share one
// stimulus stream and are checked against an elapsed-time reference model.
module tb_decoder_nx_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] sel;
  logic       in_valid;

  logic        rdy3, busy3;
  logic [7:0]  out3;
  logic [2:0]  idx3;
  logic        rdy1, busy1;
  logic [1:0]  out1;
  logic [0:0]  idx1;
  logic        rdy4, busy4;
  logic [15:0] out4;
  logic [3:0]  idx4;

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  decoder_nx_seq #(.N(3), .SCAN_DIV(4), .PULSE_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[2:0]),
    .in_valid(in_valid), .in_ready(rdy3), .out(out3), .scan_idx(idx3), .busy(busy3)
  );

  decoder_nx_seq #(.N(1), .SCAN_DIV(1), .PULSE_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[0:0]),
    .in_valid(in_valid), .in_ready(rdy1), .out(out1), .scan_idx(idx1), .busy(busy1)
  );

  decoder_nx_seq #(.N(4), .SCAN_DIV(4), .PULSE_LEN(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(rdy4), .out(out4), .scan_idx(idx4), .busy(busy4)
  );

  // Reference model per instance: scan position is derived from the anchor index
  // plus elapsed scan edges divided by the dwell; a pulse is a remaining-cycle count.
  int          nn [3] = '{3, 1, 4};
  int          sd [3] = '{4, 1, 4};
  int          pl [3] = '{3, 1, 3};
  logic [1:0]  m_ms  [3];
  logic [63:0] m_out [3];
  int          m_idx [3];
  int          m_a   [3];
  int          m_kc  [3];
  int          m_p   [3];

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      m_ms[k]  = 2'b00;
      m_out[k] = '0;
      m_idx[k] = 0;
      m_a[k]   = 0;
      m_kc[k]  = 0;
      m_p[k]   = 0;
    end
  endtask

  task automatic modelEdge(input int k, input logic [1:0] md, input logic e,
                           input logic v, input int s);
    int   w;
    int   sk;
    logic load;
    w    = 1 << nn[k];
    sk   = s % w;
    load = v && (m_p[k] == 0);
    if (md != m_ms[k]) begin
      m_ms[k]  = md;
      m_out[k] = '0;
      m_idx[k] = 0;
      m_a[k]   = 0;
      m_kc[k]  = 0;
      m_p[k]   = 0;
    end else if (!e) begin
      m_out[k] = '0;
      m_p[k]   = 0;
      if (load) begin
        m_idx[k] = sk;
        m_a[k]   = sk;
        m_kc[k]  = m_kc[k] % sd[k];
      end
    end else begin
      case (md)
        2'b00: if (load) begin
          m_idx[k] = sk;
          m_out[k] = 64'd1 << sk;
        end
        2'b01: if (load) begin
          m_idx[k] = sk;
          m_out[k] = (sk == 63) ? '1 : ((64'd1 << (sk + 1)) - 64'd1);
        end
        2'b10: begin
          if (load) begin
            m_a[k]  = sk;
            m_kc[k] = 0;
          end else begin
            m_kc[k] = m_kc[k] + 1;
          end
          m_idx[k] = (m_a[k] + m_kc[k] / sd[k]) % w;
          m_out[k] = 64'd1 << m_idx[k];
        end
        default: begin
          if (m_p[k] > 0) begin
            m_p[k] = m_p[k] - 1;
            if (m_p[k] == 0) m_out[k] = '0;
          end else if (load) begin
            m_idx[k] = sk;
            m_out[k] = 64'd1 << sk;
            m_p[k]   = pl[k];
          end
        end
      endcase
    end
  endtask

  task automatic compareValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutput();
    compareValue("out_n3",   64'(out3),  m_out[0]);
    compareValue("idx_n3",   64'(idx3),  64'(m_idx[0]));
    compareValue("busy_n3",  64'(busy3), 64'(m_p[0] > 0));
    compareValue("ready_n3", 64'(rdy3),  64'(m_p[0] == 0));
    compareValue("out_n1",   64'(out1),  m_out[1]);
    compareValue("idx_n1",   64'(idx1),  64'(m_idx[1]));
    compareValue("busy_n1",  64'(busy1), 64'(m_p[1] > 0));
    compareValue("ready_n1", 64'(rdy1),  64'(m_p[1] == 0));
    compareValue("out_n4",   64'(out4),  m_out[2]);
    compareValue("idx_n4",   64'(idx4),  64'(m_idx[2]));
    compareValue("busy_n4",  64'(busy4), 64'(m_p[2] > 0));
    compareValue("ready_n4", 64'(rdy4),  64'(m_p[2] == 0));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then sample.
  task automatic applyStimulus(input logic [1:0] md, input logic e, input logic v,
                               input logic [3:0] s);
    mode     = md;
    en       = e;
    in_valid = v;
    sel      = s;
    @(posedge clk);
    for (int k = 0; k < 3; k++) modelEdge(k, md, e, v, int'(s));
    #1;
    checkOutput();
  endtask

  logic [1:0] rmode;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    mode     = 2'b00;
    en       = 1'b0;
    in_valid = 1'b0;
    sel      = '0;
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] direct one-hot and enable");
    applyStimulus(2'b00, 1'b1, 1'b1, 4'd5);
    applyStimulus(2'b00, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b00, 1'b0, 1'b0, 4'd0);
    applyStimulus(2'b00, 1'b1, 1'b1, 4'd2);

    $display("[TB] thermometer");
    applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b01, 1'b1, 1'b1, 4'd0);
    applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b01, 1'b1, 1'b1, 4'd3);
    applyStimulus(2'b01, 1'b1, 1'b1, 4'd7);
    applyStimulus(2'b01, 1'b1, 1'b1, 4'd15);

    $display("[TB] auto-scan with wrap and reload");
    applyStimulus(2'b10, 1'b1, 1'b0, 4'd0);
    repeat (70) applyStimulus(2'b10, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b10, 1'b1, 1'b1, 4'd6);
    repeat (6) applyStimulus(2'b10, 1'b1, 1'b0, 4'd0);

    $display("[TB] asynchronous reset mid-scan");
    #2;
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput();
    #2;
    rst_n = 1'b1;

    $display("[TB] one-shot pulse");
    applyStimulus(2'b11, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b11, 1'b1, 1'b1, 4'd2);
    repeat (5) applyStimulus(2'b11, 1'b1, 1'b1, 4'd5);

    $display("[TB] abort by mode change and by enable");
    applyStimulus(2'b00, 1'b1, 1'b1, 4'd3);
    applyStimulus(2'b00, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b11, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b11, 1'b1, 1'b1, 4'd4);
    applyStimulus(2'b11, 1'b1, 1'b0, 4'd0);
    applyStimulus(2'b11, 1'b0, 1'b0, 4'd0);
    applyStimulus(2'b11, 1'b1, 1'b0, 4'd0);

    $display("[TB] randomized traffic");
    rmode = 2'b10;
    repeat (400) begin
      if ($urandom_range(15) == 0) rmode = 2'($urandom_range(3));
      applyStimulus(rmode, $urandom_range(7) != 0, 1'($urandom_range(1)),
                    4'($urandom_range(15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
